fetch_sequencer: RTL and testbench

Control FSM that sequences the SM core's program counter and instruction fetch. It drives the PC's incPC / loadFromI / I controls and the instruction-memory read enable, then presents each fetched instruction to decode over a valid/ready handshake. It also applies taken-branch redirects from execute and stops on a halt instruction. It sits in the Scheduler, between the PC, instruction memory and decode.

---
 rtl/fetch_sequencer.sv | 120 ++++++++++++
 tb/tb_fetch_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences PC increment/load and instruction fetch, then
// presents each fetched word to decode over a valid/ready handshake.
`default_nettype none

module fetch_sequencer #(
    parameter int INSTMEM_ADDR_WIDTH = 16,
    parameter int INSTR_WIDTH        = 32,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [INSTMEM_ADDR_WIDTH-1:0] AR,
    output logic                          incPC,
    output logic                          loadFromI,
    output logic [INSTMEM_ADDR_WIDTH-1:0] I,
    output logic                          imem_en,
    input  logic [INSTR_WIDTH-1:0]        imem_data,
    output logic [INSTR_WIDTH-1:0]        instr,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    input  logic                          instr_halt,
    input  logic                          br_taken,
    input  logic [INSTMEM_ADDR_WIDTH-1:0] br_target,
    output logic                          busy,
    output logic                          halted,
    output logic [CNT_WIDTH-1:0]          issue_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_ISSUE   = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [INSTR_WIDTH-1:0]   instr_q;
    logic [CNT_WIDTH-1:0]     count_q;
    logic                     capture_d;
    logic                     handshake_d;

    // AR is the PC's own register; the fetch path never needs a copy of it.
    logic unused_ar;
    assign unused_ar = ^AR;

    always_comb begin
        state_d     = state_q;
        incPC       = 1'b0;
        loadFromI   = 1'b0;
        I           = '0;
        imem_en     = 1'b0;
        instr_valid = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        capture_d   = 1'b0;
        handshake_d = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_FETCH;
                end
                S_FETCH: begin
                    busy    = 1'b1;
                    imem_en = 1'b1;
                    state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    busy      = 1'b1;
                    capture_d = 1'b1;
                    incPC     = ~br_taken;
                    state_d   = S_ISSUE;
                end
                S_ISSUE: begin
                    busy        = 1'b1;
                    instr_valid = 1'b1;
                    if (!br_taken && instr_ready) begin
                        handshake_d = 1'b1;
                        state_d     = instr_halt ? S_HALTED : S_FETCH;
                    end
                end
                S_HALTED: begin
                    halted = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
            // A taken branch overrides the in-flight instruction and refetches.
            if (busy && br_taken) begin
                loadFromI = 1'b1;
                I         = br_target;
                state_d   = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture_d)   instr_q <= imem_data;
            if (handshake_d) count_q <= count_q + 1'b1;
        end
    end

    assign instr       = instr_q;
    assign issue_count = count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(incPC && loadFromI));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer with a PC/memory environment and a
// per-instruction reference model of the fetch/issue sequence.
`default_nettype none

module tb_fetch_sequencer;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset, start, instr_ready, instr_halt, br_taken;
    logic [AW-1:0] AR, I, br_target;
    logic          incPC, loadFromI, imem_en, instr_valid, busy, halted;
    logic [DW-1:0] imem_data, instr;
    logic [CW-1:0] issue_count;

    logic [DW-1:0] mem [0:255];

    int checks   = 0;
    int failures = 0;

    fetch_sequencer #(
        .INSTMEM_ADDR_WIDTH(AW),
        .INSTR_WIDTH       (DW),
        .CNT_WIDTH         (CW)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .AR         (AR),
        .incPC      (incPC),
        .loadFromI  (loadFromI),
        .I          (I),
        .imem_en    (imem_en),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_halt (instr_halt),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .busy       (busy),
        .halted     (halted),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    // Environment: program counter and synchronous instruction memory.
    always_ff @(posedge clk) begin
        if (reset)          AR <= '0;
        else if (loadFromI) AR <= I;
        else if (incPC)     AR <= AR + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (imem_en) imem_data <= mem[AR[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1..3 = cycle within the current
    // instruction (fetch, capture, issue), 4 halted.
    int            m_phase;
    logic [AW-1:0] m_pc, m_fa;
    logic [DW-1:0] m_instr;
    logic [CW-1:0] m_count;

    initial begin
        bit done_br, done_sq, done_halt, done_rst;
        logic act;
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        AR = '0;
        m_phase = 0; m_pc = '0; m_fa = '0; m_instr = '0; m_count = '0;
        done_br = 0; done_sq = 0; done_halt = 0; done_rst = 0;
        reset = 1'b1; start = 1'b0; instr_ready = 1'b0; instr_halt = 1'b0;
        br_taken = 1'b0; br_target = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = 1'b0; start = 1'b0; instr_ready = 1'b1; instr_halt = 1'b0;
            br_taken = 1'b0; br_target = '0;
            if (cyc < 2) reset = 1'b1;
            else if (cyc == 2) start = 1'b1;
            else if (cyc >= 20 && cyc < 32) instr_ready = 1'b0;
            else if (cyc >= 40 && cyc < 60) begin
                if (m_phase == 2 && !done_br) begin
                    br_taken = 1'b1; br_target = 16'h0040; done_br = 1;
                end
            end else if (cyc >= 60 && cyc < 80) begin
                if (m_phase == 3 && !done_sq) begin
                    br_taken = 1'b1; br_target = 16'h0010; instr_halt = 1'b1; done_sq = 1;
                end
            end else if (cyc >= 90 && cyc < 125) begin
                if (m_phase == 3 && !done_halt) begin
                    instr_halt = 1'b1; done_halt = 1;
                end else if (m_phase == 4) begin
                    start = 1'b1; br_taken = 1'b1; br_target = 16'h00aa;
                end
            end else if (cyc == 125) reset = 1'b1;
            else if (cyc == 126) start = 1'b1;
            else if (cyc > 126 && cyc < 160) begin
                if (m_phase == 3 && !done_rst && m_count != 0) begin
                    instr_ready = 1'b0; reset = 1'b1; done_rst = 1;
                end
            end else if (cyc >= 160) begin
                start       = ($urandom_range(0, 3) == 0);
                instr_ready = ($urandom_range(0, 9) < 7);
                instr_halt  = ($urandom_range(0, 29) == 0);
                br_taken    = ($urandom_range(0, 9) == 0);
                br_target   = AW'($urandom_range(0, 255));
                reset       = ($urandom_range(0, 199) == 0) ||
                              (m_phase == 4 && $urandom_range(0, 5) == 0);
            end

            @(negedge clk);
            act = !reset && m_phase >= 1 && m_phase <= 3;
            check("imem_en", {31'd0, imem_en}, {31'd0, !reset && m_phase == 1});
            check("incPC", {31'd0, incPC}, {31'd0, !reset && m_phase == 2 && !br_taken});
            check("loadFromI", {31'd0, loadFromI}, {31'd0, act && br_taken});
            check("I", {16'd0, I}, (act && br_taken) ? {16'd0, br_target} : 32'd0);
            check("instr_valid", {31'd0, instr_valid}, {31'd0, !reset && m_phase == 3});
            check("busy", {31'd0, busy}, {31'd0, act});
            check("halted", {31'd0, halted}, {31'd0, !reset && m_phase == 4});
            check("issue_count", issue_count, m_count);
            check("instr", instr, m_instr);
            check("AR", {16'd0, AR}, {16'd0, m_pc});

            if (reset) begin
                m_phase = 0; m_pc = '0; m_count = '0; m_instr = '0;
            end else begin
                case (m_phase)
                    0: if (start) m_phase = 1;
                    1: begin
                        m_fa = m_pc;
                        if (br_taken) m_pc = br_target;
                        else m_phase = 2;
                    end
                    2: begin
                        m_instr = mem[m_fa[7:0]];
                        if (br_taken) begin m_pc = br_target; m_phase = 1; end
                        else begin m_pc = m_pc + 1'b1; m_phase = 3; end
                    end
                    3: begin
                        if (br_taken) begin m_pc = br_target; m_phase = 1; end
                        else if (instr_ready) begin
                            m_count = m_count + 1'b1;
                            m_phase = instr_halt ? 4 : 1;
                        end
                    end
                    default: ;
                endcase
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
